// File: rtl/jtopl_pkg.sv
// Shared register map, strobe encoding and bus wait defaults for the OPL register front end.
package jtopl_pkg;

   localparam int unsigned BUSY_W        = 8;
   localparam int unsigned ADDR_WAIT_DEF = 12;
   localparam int unsigned DATA_WAIT_DEF = 84;

   // Global registers as {bank, reg}
   localparam logic [8:0] REG_TEST      = 9'h001;
   localparam logic [8:0] REG_TIMER_A   = 9'h002;
   localparam logic [8:0] REG_TIMER_B   = 9'h003;
   localparam logic [8:0] REG_TIMER_CTL = 9'h004;
   localparam logic [8:0] REG_CSM       = 9'h008;
   localparam logic [8:0] REG_RHY       = 9'h0BD;
   localparam logic [8:0] REG_4OP       = 9'h104;
   localparam logic [8:0] REG_NEW       = 9'h105;

   typedef enum logic [3:0] {
      STB_NONE,
      STB_MULT,
      STB_KSL_TL,
      STB_AR_DR,
      STB_SL_RR,
      STB_WAV,
      STB_FNUMLO,
      STB_FNUMHI,
      STB_FBCON
   } stb_e;

   // Operator register group from reg[7:5]
   function automatic stb_e op_stb(input logic [2:0] grp);
      case (grp)
         3'd1:    op_stb = STB_MULT;
         3'd2:    op_stb = STB_KSL_TL;
         3'd3:    op_stb = STB_AR_DR;
         3'd4:    op_stb = STB_SL_RR;
         3'd7:    op_stb = STB_WAV;
         default: op_stb = STB_NONE;
      endcase
   endfunction

   // Channel register group from reg[7:4]
   function automatic stb_e ch_stb(input logic [3:0] hi);
      case (hi)
         4'hA:    ch_stb = STB_FNUMLO;
         4'hB:    ch_stb = STB_FNUMHI;
         4'hC:    ch_stb = STB_FBCON;
         default: ch_stb = STB_NONE;
      endcase
   endfunction

endpackage

// File: rtl/jtopl_busy.sv
// Bus busy counter: loaded on every accepted write, counts down on cen.
// Ports: clk, rst (sync, active-high), cen, load/load_val (start a wait), busy (registered).
module jtopl_busy
   import jtopl_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              cen,
   input  logic              load,
   input  logic [BUSY_W-1:0] load_val,
   output logic              busy
);

   logic [BUSY_W-1:0] cnt;

   // busy follows the count one clk late, so it stays high on the edge the count hits zero
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt  <= '0;
         busy <= 1'b0;
      end else if (load) begin
         cnt  <= load_val;
         busy <= 1'b1;
      end else begin
         if (cen && cnt != '0) cnt <= cnt - BUSY_W'(1);
         busy <= (cnt != '0);
      end
   end

endmodule

// File: rtl/jtopl3_mmr.sv
// OPL2/OPL3 register front end: bus write acceptance, register decode, update strobes
// and global register storage.
// Ports: clk, rst (sync, active-high), cen; bus din/addr/write; busy, wr_drop;
// up_data with sel_ch/sel_slot and one-clk up_* strobes; global register outputs.
module jtopl3_mmr
   import jtopl_pkg::*;
#(
   parameter int unsigned NCH       = 18,
   parameter int unsigned ADDR_WAIT = ADDR_WAIT_DEF,
   parameter int unsigned DATA_WAIT = DATA_WAIT_DEF
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       cen,
   input  logic [7:0] din,
   input  logic [1:0] addr,
   input  logic       write,
   output logic       busy,
   output logic       wr_drop,
   output logic [7:0] up_data,
   output logic [4:0] sel_ch,
   output logic [5:0] sel_slot,
   output logic       up_fnumlo,
   output logic       up_fnumhi,
   output logic       up_fbcon,
   output logic       up_mult,
   output logic       up_ksl_tl,
   output logic       up_ar_dr,
   output logic       up_sl_rr,
   output logic       up_wav,
   output logic       opl3_en,
   output logic [5:0] fourop,
   output logic       wave_mode,
   output logic [7:0] value_A,
   output logic [7:0] value_B,
   output logic       load_A,
   output logic       load_B,
   output logic       flagen_A,
   output logic       flagen_B,
   output logic       clr_flag_A,
   output logic       clr_flag_B,
   output logic       rhy_en,
   output logic [4:0] rhy_kon,
   output logic       am_dep,
   output logic       vib_dep,
   output logic       note_sel,
   output logic       csm_en
);

   localparam bit DUAL = (NCH > 9);

   logic [7:0]        selreg;
   logic              selbank;
   logic              accept, acc_addr, acc_data;
   logic [BUSY_W-1:0] busy_val;
   stb_e              stb;
   logic              op_hit, ch_hit, bank1_off;
   logic [5:0]        slot_nx;
   logic [4:0]        ch_nx;

   assign accept   = write & ~busy & ~rst;
   assign acc_addr = accept & ~addr[0];
   assign acc_data = accept &  addr[0];
   assign busy_val = acc_addr ? BUSY_W'(ADDR_WAIT) : BUSY_W'(DATA_WAIT);

   jtopl_busy u_busy (
      .clk      (clk),
      .rst      (rst),
      .cen      (cen),
      .load     (accept),
      .load_val (busy_val),
      .busy     (busy)
   );

   // Decode the selected register into a strobe and its slot/channel index
   always_comb begin
      stb       = STB_NONE;
      op_hit    = 1'b0;
      ch_hit    = 1'b0;
      slot_nx   = '0;
      ch_nx     = '0;
      bank1_off = DUAL && selbank && !opl3_en && (selreg != REG_NEW[7:0]);
      if (op_stb(selreg[7:5]) != STB_NONE && selreg[2:0] <= 3'd5 && selreg[4:3] != 2'd3) begin
         op_hit  = 1'b1;
         stb     = op_stb(selreg[7:5]);
         slot_nx = (selbank ? 6'd18 : 6'd0) + 6'(selreg[4:3]) * 6'd6 + 6'(selreg[2:0]);
      end else if (ch_stb(selreg[7:4]) != STB_NONE && selreg[3:0] <= 4'd8) begin
         ch_hit = 1'b1;
         stb    = ch_stb(selreg[7:4]);
         ch_nx  = (selbank ? 5'd9 : 5'd0) + 5'(selreg[3:0]);
      end
   end

   // Register file and strobe generation
   always_ff @(posedge clk) begin
      if (rst) begin
         selreg     <= '0;
         selbank    <= 1'b0;
         wr_drop    <= 1'b0;
         up_data    <= '0;
         sel_ch     <= '0;
         sel_slot   <= '0;
         up_fnumlo  <= 1'b0;
         up_fnumhi  <= 1'b0;
         up_fbcon   <= 1'b0;
         up_mult    <= 1'b0;
         up_ksl_tl  <= 1'b0;
         up_ar_dr   <= 1'b0;
         up_sl_rr   <= 1'b0;
         up_wav     <= 1'b0;
         opl3_en    <= 1'b0;
         fourop     <= '0;
         wave_mode  <= 1'b0;
         value_A    <= '0;
         value_B    <= '0;
         load_A     <= 1'b0;
         load_B     <= 1'b0;
         flagen_A   <= 1'b1;
         flagen_B   <= 1'b1;
         clr_flag_A <= 1'b0;
         clr_flag_B <= 1'b0;
         rhy_en     <= 1'b0;
         rhy_kon    <= '0;
         am_dep     <= 1'b0;
         vib_dep    <= 1'b0;
         note_sel   <= 1'b0;
         csm_en     <= 1'b0;
      end else begin
         wr_drop   <= write & busy;
         up_fnumlo <= 1'b0;
         up_fnumhi <= 1'b0;
         up_fbcon  <= 1'b0;
         up_mult   <= 1'b0;
         up_ksl_tl <= 1'b0;
         up_ar_dr  <= 1'b0;
         up_sl_rr  <= 1'b0;
         up_wav    <= 1'b0;

         if (acc_addr) begin
            selreg  <= din;
            selbank <= DUAL ? addr[1] : 1'b0;
         end

         if (acc_data && !bank1_off) begin
            up_data <= din;
            case (stb)
               STB_MULT:   up_mult   <= 1'b1;
               STB_KSL_TL: up_ksl_tl <= 1'b1;
               STB_AR_DR:  up_ar_dr  <= 1'b1;
               STB_SL_RR:  up_sl_rr  <= 1'b1;
               STB_WAV:    up_wav    <= 1'b1;
               STB_FNUMLO: up_fnumlo <= 1'b1;
               STB_FNUMHI: up_fnumhi <= 1'b1;
               STB_FBCON:  up_fbcon  <= 1'b1;
               default: ;
            endcase
            if (op_hit) sel_slot <= slot_nx;
            if (ch_hit) sel_ch   <= ch_nx;
            case ({selbank, selreg})
               REG_TEST:    wave_mode <= din[5];
               REG_TIMER_A: value_A   <= din;
               REG_TIMER_B: value_B   <= din;
               REG_TIMER_CTL: begin
                  clr_flag_A <= din[7];
                  clr_flag_B <= din[7];
                  flagen_A   <= ~din[6];
                  flagen_B   <= ~din[5];
                  load_B     <= din[1];
                  load_A     <= din[0];
               end
               REG_CSM:     {csm_en, note_sel} <= din[7:6];
               REG_RHY:     {am_dep, vib_dep, rhy_en, rhy_kon} <= din;
               REG_4OP:     fourop  <= din[5:0];
               REG_NEW:     opl3_en <= din[0];
               default: ;
            endcase
         end

         // flag-clear request lasts until a quiet chip tick
         if (!accept && cen) begin
            clr_flag_A <= 1'b0;
            clr_flag_B <= 1'b0;
         end
      end
   end

endmodule
